// File: rtl/bmp_pkg.sv
// bmp_pkg: shared constants, stream-state enum and width helpers
// for the bitmap slice streamer (bmp_slicer and bmp_slice_stream).
package bmp_pkg;

    localparam int ROWS_DEF = 64;
    localparam int COLS_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } stream_st_e;

    // Index width for a counter over n positions (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flattened bitmap width.
    function automatic int bmp_w(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/bmp_slice_stream.sv
// bmp_slice_stream: one slice stream (IDLE/ACTIVE/DONE FSM, index, last).
// Ports: clk, rst_n, restart (load), ready -> valid, last, idx, finished.
module bmp_slice_stream
    import bmp_pkg::*;
#(
    parameter int COUNT   = COLS_DEF,
    parameter bit DESCEND = 1'b0,
    localparam int W      = idx_w(COUNT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    input  logic         ready,
    output logic         valid,
    output logic         last,
    output logic [W-1:0] idx,
    output logic         finished
);

    localparam logic [W-1:0] FIRST = DESCEND ? '0 : '0;
    localparam logic [W-1:0] TOP_I = W'(COUNT - 1);
    localparam logic [W-1:0] START = DESCEND ? TOP_I : FIRST;
    localparam logic [W-1:0] FINAL = DESCEND ? FIRST : TOP_I;

    stream_st_e   state_q, state_d;
    logic [W-1:0] idx_q, idx_d;

    // A restart overrides any handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (restart) begin
            state_d = ST_ACTIVE;
            idx_d   = START;
        end else begin
            unique case (state_q)
                ST_ACTIVE: begin
                    if (ready) begin
                        // Final slice: hold the index, DONE blocks wrap.
                        if (idx_q == FINAL) begin
                            state_d = ST_DONE;
                        end else if (DESCEND) begin
                            idx_d = idx_q - W'(1);
                        end else begin
                            idx_d = idx_q + W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= START;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign valid    = (state_q == ST_ACTIVE);
    assign last     = valid && (idx_q == FINAL);
    assign idx      = idx_q;
    assign finished = (state_q == ST_DONE);

endmodule

// File: rtl/bmp_slicer.sv
// bmp_slicer: captures a ROWS x COLS bitmap on load and streams columns,
// bottom-up rows and top-down rows over three valid/ready channels.
// Ports: load/bmp_in in; start, done, {col,bot,top}_{out,valid,last} out;
// {col,bot,top}_ready in.
module bmp_slicer
    import bmp_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] bmp_in,
    output logic                 start,
    output logic [ROWS-1:0]      col_out,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic                 col_last,
    output logic [COLS-1:0]      bot_out,
    output logic                 bot_valid,
    input  logic                 bot_ready,
    output logic                 bot_last,
    output logic [COLS-1:0]      top_out,
    output logic                 top_valid,
    input  logic                 top_ready,
    output logic                 top_last,
    output logic                 done
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int BW = bmp_w(ROWS, COLS);

    logic [BW-1:0]   bmp_q, bmp_d;
    logic            start_q, start_d;
    logic [CW-1:0]   col_idx;
    logic [RW-1:0]   bot_idx, top_idx;
    logic            col_fin, bot_fin, top_fin;
    logic [ROWS-1:0] col_s;
    logic [COLS-1:0] bot_s, top_s;

    always_comb begin
        bmp_d   = load ? bmp_in : bmp_q;
        start_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmp_q   <= '0;
            start_q <= 1'b0;
        end else begin
            bmp_q   <= bmp_d;
            start_q <= start_d;
        end
    end

    bmp_slice_stream #(.COUNT(COLS), .DESCEND(1'b0)) u_col (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load),
        .ready    (col_ready),
        .valid    (col_valid),
        .last     (col_last),
        .idx      (col_idx),
        .finished (col_fin)
    );

    bmp_slice_stream #(.COUNT(ROWS), .DESCEND(1'b0)) u_bot (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load),
        .ready    (bot_ready),
        .valid    (bot_valid),
        .last     (bot_last),
        .idx      (bot_idx),
        .finished (bot_fin)
    );

    bmp_slice_stream #(.COUNT(ROWS), .DESCEND(1'b1)) u_top (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load),
        .ready    (top_ready),
        .valid    (top_valid),
        .last     (top_last),
        .idx      (top_idx),
        .finished (top_fin)
    );

    // Column slice: row 0 lands in the MSB.
    always_comb begin
        col_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            col_s[ROWS-1-r] = bmp_q[r*COLS + int'(col_idx)];
        end
        bot_s = bmp_q[int'(bot_idx)*COLS +: COLS];
        top_s = bmp_q[int'(top_idx)*COLS +: COLS];
    end

    // Slices are forced to zero whenever their stream is not valid.
    assign col_out = col_valid ? col_s : '0;
    assign bot_out = bot_valid ? bot_s : '0;
    assign top_out = top_valid ? top_s : '0;
    assign start   = start_q;
    assign done    = col_fin & bot_fin & top_fin;

endmodule
